// File: rtl/operand_triple_feeder.sv
// operand_triple_feeder: packs bytes into three operands, captures the compute result and hands it downstream (FEEDER_PARITY_EN adds out_parity)
module operand_triple_feeder #(
  parameter int DATA_W = 8,
  parameter int RES_W = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] membr_1,
  output logic [DATA_W-1:0] membr_2,
  output logic [DATA_W-1:0] membr_3,
  input  logic [RES_W-1:0]  y_all,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [7:0]        out_count
`ifdef FEEDER_PARITY_EN
  ,
  output logic              out_parity
`endif
);
  typedef enum logic [2:0] {LOAD1, LOAD2, LOAD3, SETTLE, HOLD} state_t;
  state_t state, state_nxt;
  logic take;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD1;
    else state <= state_nxt;
  // next state: loads advance on a transfer, settle lasts one cycle, hold waits for out_ready
  always_comb begin
    state_nxt = state == SETTLE ? HOLD :
                state == HOLD   ? (out_ready ? LOAD1 : HOLD) :
                !take           ? state :
                state == LOAD1  ? LOAD2 :
                state == LOAD2  ? LOAD3 : SETTLE;
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready = state == LOAD1 || state == LOAD2 || state == LOAD3;
    out_valid = state == HOLD;
    take = in_valid && in_ready;
  end
  // operand, result and handoff-count registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      membr_1 <= '0;
      membr_2 <= '0;
      membr_3 <= '0;
      out_data <= '0;
      out_count <= '0;
`ifdef FEEDER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (take && state == LOAD1) membr_1 <= in_data;
      if (take && state == LOAD2) membr_2 <= in_data;
      if (take && state == LOAD3) membr_3 <= in_data;
      if (state == SETTLE) out_data <= y_all;
`ifdef FEEDER_PARITY_EN
      if (state == SETTLE) out_parity <= ^y_all;
`endif
      if (state == HOLD && out_ready) out_count <= out_count + 8'd1;
    end
endmodule

// File: tb/tb_operand_triple_feeder.sv
// tb_operand_triple_feeder: directed and randomized triples checked against a transaction-level model
module tb_operand_triple_feeder;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid;
  logic [7:0] membr_1, membr_2, membr_3, out_count;
  logic [16:0] y_all, out_data;
`ifdef FEEDER_PARITY_EN
  logic out_parity;
`endif
  int checks = 0, errors = 0;
  logic [7:0] exp_m1, exp_m2, exp_m3, exp_cnt;
  logic [16:0] exp_res;

  operand_triple_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .membr_1(membr_1), .membr_2(membr_2), .membr_3(membr_3), .y_all(y_all),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_count(out_count)
`ifdef FEEDER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  // stand-in compute block
  assign y_all = 17'(membr_1) + 17'(membr_2) + 17'(membr_3);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_m1"}, 32'(membr_1), 32'(exp_m1));
    check({tag, "_m2"}, 32'(membr_2), 32'(exp_m2));
    check({tag, "_m3"}, 32'(membr_3), 32'(exp_m3));
    check({tag, "_data"}, 32'(out_data), 32'(exp_res));
    check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
  endtask

  task automatic do_reset;
    rst_n = 0;
    #1;
    exp_m1 = 0; exp_m2 = 0; exp_m3 = 0; exp_res = 0; exp_cnt = 0;
    check_regs("reset");
    check("reset_valid", 32'(out_valid), 0);
    check("reset_ready", 32'(in_ready), 1);
`ifdef FEEDER_PARITY_EN
    check("reset_parity", 32'(out_parity), 0);
`endif
    in_valid = 1; in_data = 8'hAA;
    step;
    check_regs("in_reset");
    in_valid = 0; out_ready = 0;
    rst_n = 1;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input int k);
    in_valid = 0;
    repeat (gap) begin
      in_data = 8'($urandom);
      check("gap_ready", 32'(in_ready), 1);
      step;
    end
    in_valid = 1; in_data = b;
    check("load_ready", 32'(in_ready), 1);
    check("load_valid", 32'(out_valid), 0);
    step;
    if (k == 1) exp_m1 = b;
    else if (k == 2) exp_m2 = b;
    else exp_m3 = b;
    check_regs("load");
  endtask

  task automatic triple(input logic [7:0] b1, b2, b3, input int g1, g2, g3, hold);
    logic [16:0] sum;
    send(b1, g1, 1);
    send(b2, g2, 2);
    send(b3, g3, 3);
    sum = 17'(b1) + 17'(b2) + 17'(b3);
    in_valid = 1'($urandom); in_data = 8'($urandom); out_ready = 1'($urandom);
    check("settle_valid", 32'(out_valid), 0);
    check("settle_ready", 32'(in_ready), 0);
    step;
    exp_res = sum;
    check("hold_valid", 32'(out_valid), 1);
    check("hold_ready", 32'(in_ready), 0);
    check_regs("hold");
`ifdef FEEDER_PARITY_EN
    check("hold_parity", 32'(out_parity), 32'(^sum));
`endif
    repeat (hold) begin
      out_ready = 0;
      step;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_ready", 32'(in_ready), 0);
      check_regs("stall");
    end
    out_ready = 1;
    step;
    exp_cnt = exp_cnt + 8'd1;
    check("handoff_valid", 32'(out_valid), 0);
    check("handoff_ready", 32'(in_ready), 1);
    check_regs("handoff");
    out_ready = 0; in_valid = 0;
  endtask

  initial begin
    do_reset;
    triple(1, 2, 3, 0, 0, 0, 0);
    triple(4, 5, 6, 0, 0, 0, 4);
    triple(255, 255, 255, 0, 0, 0, 1);
    triple(7, 8, 9, 1, 3, 2, 0);
    send(10, 0, 1);
    send(11, 0, 2);
    do_reset;
    send(12, 0, 1);
    send(13, 0, 2);
    send(14, 0, 3);
    in_valid = 0;
    step;
    check("pre_reset_valid", 32'(out_valid), 1);
    check("pre_reset_data", 32'(out_data), 39);
    do_reset;
    triple(1, 1, 1, 0, 0, 0, 0);
    repeat (8) triple(8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));
    do_reset;
    repeat (256) triple(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
    check("wrap_count", 32'(out_count), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_triple_feeder.md
# operand_triple_feeder

Sequential front end for the team's three-operand combinational compute block. It accepts a byte stream over a valid/ready handshake and packs it into three 8-bit operand registers that drive the compute block directly. After one settle cycle it captures the block's 17-bit result and offers it downstream over a second valid/ready handshake. It is the producer/collector end of the compute block's operand interface: it drives the operands and consumes the result.

## Interface
- DATA_W, 8, operand/byte width
- RES_W, 17, result width (fixed relation: 2*DATA_W+1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  DATA_W  upstream byte
- in_ready  out  1  feeder can accept a byte
- membr_1, membr_2, membr_3  out  DATA_W each  registered operands to compute block
- y_all  in  RES_W  combinational result from compute block
- out_valid  out  1  result available
- out_data  out  RES_W  captured result
- out_ready  in  1  downstream accepts result
- out_count  out  8  number of results handed off, wraps 255->0
- out_parity  out  1  only with FEEDER_PARITY_EN (see Configuration)

## Operation
- FSM states: LOAD1, LOAD2, LOAD3, SETTLE, HOLD; reset state LOAD1.
- in_ready = 1 in LOAD1/LOAD2/LOAD3, 0 in SETTLE/HOLD (decoded from state).
- LOADk: on in_valid&&in_ready, in_data -> membr_k, advance to next state (LOAD3 -> SETTLE). No transfer means hold state.
- SETTLE: one cycle only; operands are stable and y_all settles; unconditionally -> HOLD, capturing y_all into out_data and setting out_valid=1 on that edge.
- HOLD: out_valid=1, out_data stable; on out_ready=1 clear out_valid, increment out_count mod 256, -> LOAD1.
- membr_1..3 hold their values until overwritten by a new byte; the old membr_2/membr_3 stay visible while LOAD1/LOAD2 refill.
- out_data holds its last captured value after handoff until the next capture.
- Width: y_all is captured unmodified, full RES_W bits, no truncation.

## Timing
- Reset (async assert, rst_n low) forces: state LOAD1, membr_1..3=0, out_data=0, out_valid=0, out_count=0, out_parity=0. in_ready reads 1, but no byte is accepted while rst_n is low.
- Reset asserted mid-triple or in HOLD discards partial operands and any pending result, with no handoff and no count change.
- Latency: if the third byte is accepted at edge N, the state is SETTLE in cycle N..N+1, and out_valid/out_data are valid after edge N+1.
- out_ready high when out_valid is already high: handoff occurs at that edge. in_ready rises the cycle after handoff, so there is no same-cycle overlap.
- out_ready high while out_valid=0 is ignored.
- Minimum period per triple, with in_valid and out_ready always high: 5 cycles (3 load, 1 settle, 1 hold).
- out_count increments exactly once per handoff. Wrap 255->0 is silent.

## Configuration
- FEEDER_PARITY_EN defined: the out_parity port exists and is registered with out_data as the XOR-reduce of y_all at capture. It is 0 at reset.
- FEEDER_PARITY_EN undefined: the out_parity port and its logic are absent. All other behaviour is identical.

## Test plan
- Bench models y_all = membr_1+membr_2+membr_3 (zero-extended to 17 bits).
- Reset, then bytes 1,2,3 with in_valid held high and out_ready=1 -> membr=1/2/3, out_valid pulses one cycle 2 edges after byte 3, out_data=6, out_count=1.
- Bytes 4,5,6 with out_ready=0 for 4 cycles -> out_valid held with out_data=15 and in_ready=0 throughout. Handoff on out_ready; out_count increments once.
- Bytes 255,255,255 -> out_data=765. With FEEDER_PARITY_EN, out_parity=0 (765=0b1011111101, 8 ones).
- in_valid gaps of 0–3 cycles between bytes 7,8,9 -> no extra captures, out_data=24 at the same relative latency from byte 9.
- Assert rst_n after bytes 10,11 and again in HOLD -> all outputs return to reset values immediately, no result is emitted, and the next triple 1,1,1 gives out_data=3.
- 256 back-to-back triples -> out_count wraps to 0 and each triple takes 5 cycles.
